// File: rtl/pll_reset_sequencer.sv
// Brings up the CPU/PPU clock PLL: holds it in reset, waits for a stable lock, then releases PPU and CPU resets staggered.
// Latency: lock loss reaches the reset outputs 3 refclk edges after pll_locked falls (2 sync + 1 state).
// Backpressure: none; soft_rst is honoured only in RUN and lock loss always wins over it.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int LOCK_STABLE    = 1024,
    parameter int STAGGER        = 8,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_rst,
    output logic       pll_rst,
    output logic       ppu_rst,
    output logic       cpu_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] retry_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_REL_PPU   = 3'd3,
        ST_RUN       = 3'd4,
        ST_SOFT      = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRY);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       retry_nxt;
    logic             lock_meta;
    logic             lock_s;

    // pll_locked is asynchronous to refclk; only lock_s may be used downstream.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= ST_PLL_RST;
            cnt       <= '0;
            retry_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        case (state)
            ST_PLL_RST: begin
                if (cnt == PLL_RST_LAST) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_cnt == RETRY_MAX) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        retry_nxt = retry_cnt + 3'd1;
                        state_nxt = ST_PLL_RST;
                    end
                end
            end
            ST_STABLE: begin
                // A glitch restarts the lock wait without spending a retry.
                if (!lock_s)                  state_nxt = ST_WAIT_LOCK;
                else if (cnt == STABLE_LAST)  state_nxt = ST_REL_PPU;
            end
            ST_REL_PPU: begin
                if (!lock_s)                  state_nxt = ST_PLL_RST;
                else if (cnt == STAGGER_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s)                  state_nxt = ST_PLL_RST;
                else if (soft_rst)            state_nxt = ST_SOFT;
            end
            ST_SOFT: begin
                if (!lock_s)                  state_nxt = ST_PLL_RST;
                else if (cnt == STAGGER_LAST) state_nxt = ST_REL_PPU;
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_PLL_RST;
            end
        endcase
        if (state_nxt == ST_RUN && state != ST_RUN) retry_nxt = 3'd0;
    end

    // Outputs decode the state register only, so async rst forces them immediately.
    always_comb begin
        pll_rst = 1'b0;
        ppu_rst = 1'b1;
        cpu_rst = 1'b1;
        ready   = 1'b0;
        fault   = 1'b0;
        case (state)
            ST_PLL_RST: pll_rst = 1'b1;
            ST_REL_PPU: ppu_rst = 1'b0;
            ST_RUN: begin
                ppu_rst = 1'b0;
                cpu_rst = 1'b0;
                ready   = 1'b1;
            end
            ST_FAULT: begin
                pll_rst = 1'b1;
                fault   = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboarded bench for pll_reset_sequencer: per-cycle expected outputs come from a phase/age reference model.
module tb_pll_reset_sequencer;

    localparam int P_RST  = 4;
    localparam int P_TO   = 20;
    localparam int P_STB  = 8;
    localparam int P_STG  = 2;
    localparam int P_MAXR = 2;

    localparam int PH_HOLD = 0, PH_WAIT = 1, PH_STABLE = 2, PH_PPU = 3,
                   PH_RUN = 4, PH_SOFT = 5, PH_FAULT = 6;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       soft_rst;
    logic       pll_rst;
    logic       ppu_rst;
    logic       cpu_rst;
    logic       ready;
    logic       fault;
    logic [2:0] retry_cnt;
    logic [2:0] state_o;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(P_RST),
        .LOCK_TIMEOUT  (P_TO),
        .LOCK_STABLE   (P_STB),
        .STAGGER       (P_STG),
        .MAX_RETRY     (P_MAXR),
        .CNT_W         (16)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .soft_rst  (soft_rst),
        .pll_rst   (pll_rst),
        .ppu_rst   (ppu_rst),
        .cpu_rst   (cpu_rst),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt),
        .state_o   (state_o)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    // Reference model: current phase, cycles spent in it, retries used, and
    // the lock value as the sequencer sees it two edges late.
    int   m_ph;
    int   m_age;
    int   m_retry;
    logic m_hist1;
    logic m_hist2;

    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned cyc;
    logic [10:0] exp_q[$];

    function automatic int phase_len(input int ph);
        case (ph)
            PH_HOLD:        return P_RST;
            PH_WAIT:        return P_TO;
            PH_STABLE:      return P_STB;
            PH_PPU, PH_SOFT: return P_STG;
            default:        return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_ph    = PH_HOLD;
        m_age   = 0;
        m_retry = 0;
        m_hist1 = 1'b0;
        m_hist2 = 1'b0;
    endtask

    task automatic model_edge(input logic lk, input logic sr);
        int  nxt;
        bit  done;
        logic seen;
        seen = m_hist2;
        nxt  = m_ph;
        done = (m_age + 1 == phase_len(m_ph));
        if (m_ph == PH_WAIT) begin
            if (seen) nxt = PH_STABLE;
            else if (done) begin
                if (m_retry >= P_MAXR) nxt = PH_FAULT;
                else begin
                    m_retry = m_retry + 1;
                    nxt = PH_HOLD;
                end
            end
        end else if (m_ph == PH_HOLD) begin
            if (done) nxt = PH_WAIT;
        end else if (m_ph == PH_STABLE) begin
            if (!seen) nxt = PH_WAIT;
            else if (done) nxt = PH_PPU;
        end else if (m_ph != PH_FAULT) begin
            if (!seen) nxt = PH_HOLD;
            else if (m_ph == PH_RUN && sr) nxt = PH_SOFT;
            else if (m_ph == PH_PPU && done) nxt = PH_RUN;
            else if (m_ph == PH_SOFT && done) nxt = PH_PPU;
        end
        if (nxt == PH_RUN && m_ph != PH_RUN) m_retry = 0;
        m_age   = (nxt == m_ph) ? m_age + 1 : 0;
        m_ph    = nxt;
        m_hist2 = m_hist1;
        m_hist1 = lk;
    endtask

    // Expected {pll_rst,ppu_rst,cpu_rst,ready,fault, retry_cnt, state}.
    function automatic logic [10:0] exp_vec();
        logic [4:0] o;
        case (m_ph)
            PH_HOLD:  o = 5'b11100;
            PH_PPU:   o = 5'b00100;
            PH_RUN:   o = 5'b00010;
            PH_FAULT: o = 5'b11101;
            default:  o = 5'b01100;
        endcase
        return {o, 3'(m_retry), 3'(m_ph)};
    endfunction

    task automatic tick(input logic lk, input logic sr);
        pll_locked = lk;
        soft_rst   = sr;
        @(posedge refclk);
        if (rst) model_reset();
        else     model_edge(lk, sr);
        exp_q.push_back(exp_vec());
        #1;
    endtask

    task automatic run(input int n, input logic lk);
        for (int i = 0; i < n; i++) tick(lk, 1'b0);
    endtask

    // Asserted between edges: the pending expectation becomes the reset vector,
    // so the next sample checks the asynchronous path.
    task automatic reset_dut();
        rst        = 1'b1;
        pll_locked = 1'b0;
        soft_rst   = 1'b0;
        model_reset();
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = exp_vec();
        repeat (3) tick(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic run_until(input int ph, input int age, input logic lk);
        int i;
        for (i = 0; i < 200 && !(m_ph == ph && m_age == age); i++) tick(lk, 1'b0);
        n_tests++;
        if (!(m_ph == ph && m_age == age)) begin
            n_fail++;
            $display("FAIL reach_phase: model at phase %0d age %0d, needed phase %0d age %0d", m_ph, m_age, ph, age);
        end
    endtask

    // Monitor: every sampled cycle that has an expectation is compared.
    initial begin
        logic [10:0] e;
        logic [10:0] a;
        cyc = 0;
        forever begin
            @(negedge refclk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pll_rst, ppu_rst, cpu_rst, ready, fault, retry_cnt, state_o};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs cyc %0d: got rst/rdy/flt=%b retry=%0d state=%0d, want rst/rdy/flt=%b retry=%0d state=%0d",
                             cyc, a[10:6], a[5:3], a[2:0], e[10:6], e[5:3], e[2:0]);
                end
            end
        end
    end

    initial begin
        int   len;
        logic lk;
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;
        soft_rst   = 1'b0;
        model_reset();

        // Clean bring-up: lock arrives 3 cycles after pll_rst falls.
        reset_dut();
        run(P_RST + 3, 1'b0);
        run(25, 1'b1);

        // soft_rst in RUN, extra pulses while not in RUN, then lock loss colliding with soft_rst.
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        run(8, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        run(P_RST + 2, 1'b0);
        run(25, 1'b1);

        // Lock loss in RUN and recovery.
        run(5, 1'b0);
        run(30, 1'b1);

        // Lock glitch while the stable count is at 5.
        reset_dut();
        run_until(PH_STABLE, 5, 1'b1);
        run(3, 1'b0);
        run(30, 1'b1);

        // Never locks: three timeouts, then FAULT held until rst.
        reset_dut();
        run(3 * (P_RST + P_TO) + 15, 1'b0);
        run(10, 1'b1);
        reset_dut();
        run(P_RST + 2, 1'b0);
        run(25, 1'b1);

        // Async rst in the middle of REL_PPU, after one retry was spent.
        reset_dut();
        run(P_RST + P_TO + 1, 1'b0);
        run_until(PH_PPU, 0, 1'b1);
        reset_dut();
        run(P_RST, 1'b0);
        run(25, 1'b1);

        // Random lock runs with sporadic soft_rst pulses.
        repeat (4) begin
            reset_dut();
            for (int c = 0; c < 300; c += len) begin
                len = $urandom_range(1, 30);
                lk  = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < len; k++) tick(lk, ($urandom_range(0, 15) == 0));
            end
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge refclk);
        #1;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
